// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL opcodes, field widths and responder state encoding
package tl_ul_pkg;
  localparam int ADDR_W   = 28;
  localparam int SOURCE_W = 5;
  localparam int SIZE_W   = 3;
  localparam int DATA_W   = 32;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/tl_ul_lane_mask.sv
// tl_ul_lane_mask: byte-lane mask and alignment check for a 32-bit TL-UL beat
module tl_ul_lane_mask
  import tl_ul_pkg::*;
(
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        addr_lsb,
  output logic [3:0]        lane_mask,
  output logic              align_ok
);
  // sizes above a word never align, so the mask value is irrelevant for them
  always_comb begin
    lane_mask = size == 3'd0 ? 4'b0001 << addr_lsb :
                size == 3'd1 ? 4'b0011 << {addr_lsb[1], 1'b0} : 4'b1111;
    align_ok  = size == 3'd0 || (size == 3'd1 && !addr_lsb[0]) ||
                (size == 3'd2 && addr_lsb == 2'b00);
  end
endmodule

// File: rtl/tl_ul_reg_responder.sv
// tl_ul_reg_responder: TL-UL manager terminating a register bank, one request outstanding
module tl_ul_reg_responder
  import tl_ul_pkg::*;
#(
  parameter int                NREGS       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 28'h000_0000,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [2:0]          d_param,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_sink,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [DATA_W-1:0]   d_data
);
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            d_opcode_q, d_opcode_d;
  logic [SIZE_W-1:0]     d_size_q, d_size_d;
  logic [SOURCE_W-1:0]   d_source_q, d_source_d;
  logic                  d_denied_q, d_denied_d, d_corrupt_q, d_corrupt_d;
  logic [DATA_W-1:0]     d_data_q, d_data_d;
  logic [DATA_W-1:0]     regs_q [NREGS];
  logic [DATA_W-1:0]     regs_d [NREGS];
  logic [3:0]            lane_mask;
  logic                  align_ok, is_put, is_get, legal, a_fire, d_fire;
  logic [ADDR_W-1:0]     offset;
  logic [DATA_W-1:0]     rdata;
  logic                  unused_ok;

  tl_ul_lane_mask u_lane (
    .size      (a_size),
    .addr_lsb  (a_address[1:0]),
    .lane_mask (lane_mask),
    .align_ok  (align_ok)
  );

  // addresses below BASE_ADDR wrap to a huge offset and fail the range check
  assign offset    = a_address - BASE_ADDR;
  assign is_put    = a_opcode == PUT_FULL || a_opcode == PUT_PARTIAL;
  assign is_get    = a_opcode == GET;
  assign legal     = (is_put || is_get) && align_ok &&
                     offset[ADDR_W-1:2] < (ADDR_W-2)'(NREGS) &&
                     a_mask != 4'b0000 && (a_mask & ~lane_mask) == 4'b0000 &&
                     (a_opcode != PUT_FULL || a_mask == lane_mask);
  assign a_ready   = state_q == IDLE || (state_q == RESP && d_ready && WAIT_CYCLES == 0);
  assign a_fire    = a_valid && a_ready;
  assign d_valid   = state_q == RESP;
  assign d_fire    = d_valid && d_ready;
  assign d_opcode  = d_opcode_q;
  assign d_param   = 3'd0;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_sink    = 1'b0;
  assign d_denied  = d_denied_q;
  assign d_corrupt = d_corrupt_q;
  assign d_data    = d_data_q;
  assign unused_ok = ^{a_param, offset[1:0]};

  // read mux over the register bank
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGS; i++)
      if (offset[ADDR_W-1:2] == (ADDR_W-2)'(i)) rdata = regs_q[i];
  end

  // legal puts merge the enabled byte lanes into the addressed register
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (a_fire && legal && is_put && offset[ADDR_W-1:2] == (ADDR_W-2)'(i))
        for (int b = 0; b < 4; b++)
          if (a_mask[b]) regs_d[i][8*b +: 8] = a_data[8*b +: 8];
    end
  end

  // sequencing and response capture; a new accept overrides the D-fire return to idle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;
    if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end
    if (d_fire) state_d = IDLE;
    if (a_fire) begin
      state_d     = WAIT_CYCLES > 0 ? WAIT : RESP;
      cnt_d       = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
      d_opcode_d  = is_put ? ACCESS_ACK : ACCESS_ACK_DATA;
      d_size_d    = a_size;
      d_source_d  = a_source;
      d_denied_d  = !legal;
      d_corrupt_d = !legal && !is_put;
      d_data_d    = legal && is_get ? rdata : '0;
    end
  end

  // all state, response fields and registers clear asynchronously on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end
endmodule

// File: tb/tb_tl_ul_reg_responder.sv
// tb_tl_ul_reg_responder: directed and random checks of the TL-UL register responder
module tb_tl_ul_reg_responder;
  localparam int          NR    = 8;
  localparam logic [27:0] BASE  = 28'h000_1000;
  localparam logic [27:0] BASE3 = 28'h000_0100;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [4:0]  src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rsp_t;

  logic clock = 0, reset_n = 0;
  always #5 clock = ~clock;

  logic        a_valid = 0, d_ready = 1;
  logic [2:0]  a_opcode = 0, a_param = 0, a_size = 0;
  logic [4:0]  a_source = 0;
  logic [27:0] a_address = 0;
  logic [3:0]  a_mask = 0;
  logic [31:0] a_data = 0;
  logic        a_ready, d_valid, d_sink, d_denied, d_corrupt;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [4:0]  d_source;
  logic [31:0] d_data;

  logic        a_valid3 = 0, d_ready3 = 1;
  logic [2:0]  a_opcode3 = 0, a_param3 = 0, a_size3 = 0;
  logic [4:0]  a_source3 = 0;
  logic [27:0] a_address3 = 0;
  logic [3:0]  a_mask3 = 0;
  logic [31:0] a_data3 = 0;
  logic        a_ready3, d_valid3, d_sink3, d_denied3, d_corrupt3;
  logic [2:0]  d_opcode3, d_param3, d_size3;
  logic [4:0]  d_source3;
  logic [31:0] d_data3;

  int tests = 0, fails = 0;
  rsp_t mq[$];
  logic [31:0] mem [NR];

  tl_ul_reg_responder #(.NREGS(NR), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut (
    .clock(clock), .reset_n(reset_n), .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .d_valid(d_valid),
    .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data)
  );

  tl_ul_reg_responder #(.NREGS(4), .BASE_ADDR(BASE3), .WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .a_valid(a_valid3), .a_ready(a_ready3),
    .a_opcode(a_opcode3), .a_param(a_param3), .a_size(a_size3), .a_source(a_source3),
    .a_address(a_address3), .a_mask(a_mask3), .a_data(a_data3), .d_valid(d_valid3),
    .d_ready(d_ready3), .d_opcode(d_opcode3), .d_param(d_param3), .d_size(d_size3),
    .d_source(d_source3), .d_sink(d_sink3), .d_denied(d_denied3), .d_corrupt(d_corrupt3),
    .d_data(d_data3)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // What the responder must answer for one request; applies legal writes to mem.
  function automatic rsp_t model(input logic [2:0] op, input logic [2:0] sz, input logic [27:0] addr,
                                 input logic [3:0] m, input logic [31:0] dat, input logic [4:0] src);
    rsp_t r;
    int lane, idx;
    bit get, ok;
    get  = !(op == 3'd0 || op == 3'd1);
    idx  = (int'(addr) - int'(BASE)) / 4;
    lane = 0;
    ok   = (op == 3'd0 || op == 3'd1 || op == 3'd4) && sz <= 3'd2 && addr >= BASE && idx < NR;
    if (ok) begin
      lane = ((1 << (1 << sz)) - 1) << (int'(addr) % 4);
      ok = (int'(addr) % (1 << sz)) == 0 && m != 4'd0 && (int'(m) & ~lane) == 0 &&
           (op != 3'd0 || int'(m) == lane);
    end
    r.op   = get ? 3'd1 : 3'd0;
    r.size = sz;
    r.src  = src;
    r.den  = !ok;
    r.cor  = !ok && get;
    r.data = 32'd0;
    if (ok && get) r.data = mem[idx];
    if (ok && !get)
      for (int b = 0; b < 4; b++) if (m[b]) mem[idx][8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // per-cycle scoreboard check of the zero-wait responder
  always @(negedge clock) begin
    if (!reset_n) begin
      mq.delete();
      foreach (mem[i]) mem[i] = 32'd0;
    end else begin
      bit ea;
      ea = mq.size() == 0 || d_ready;
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("d_valid", 32'(d_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("d_opcode", 32'(d_opcode), 32'(mq[0].op));
        chk("d_size", 32'(d_size), 32'(mq[0].size));
        chk("d_source", 32'(d_source), 32'(mq[0].src));
        chk("d_denied", 32'(d_denied), 32'(mq[0].den));
        chk("d_corrupt", 32'(d_corrupt), 32'(mq[0].cor));
        chk("d_param", 32'(d_param), 32'd0);
        chk("d_sink", 32'(d_sink), 32'd0);
        if (mq[0].op == 3'd1) chk("d_data", d_data, mq[0].data);
        if (d_ready) void'(mq.pop_front());
      end
      if (a_valid && ea) mq.push_back(model(a_opcode, a_size, a_address, a_mask, a_data, a_source));
    end
  end

  task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [27:0] addr,
                     input logic [3:0] m, input logic [31:0] dat, input logic [4:0] src,
                     output rsp_t r, output int lat);
    int n = 0;
    @(posedge clock); #1;
    a_valid = 1; a_opcode = op; a_size = sz; a_address = addr; a_mask = m; a_data = dat;
    a_source = src; a_param = 3'($urandom);
    @(negedge clock);
    while (!a_ready && n < 20) begin @(negedge clock); n++; end
    chk("req accept", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_valid = 0;
    lat = 1;
    @(negedge clock);
    while (!d_valid && lat < 20) begin @(negedge clock); lat++; end
    r.op = d_opcode; r.size = d_size; r.src = d_source; r.den = d_denied;
    r.cor = d_corrupt; r.data = d_data;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rsp_t r;
    int lat;
    logic [31:0] vals [4];
    repeat (3) @(posedge clock);
    #2 reset_n = 1;
    @(negedge clock);
    chk("rst d_valid", 32'(d_valid), 32'd0);
    chk("rst a_ready", 32'(a_ready), 32'd1);
    chk("rst d_opcode", 32'(d_opcode), 32'd0);
    chk("rst d_source", 32'(d_source), 32'd0);
    chk("rst d_size", 32'(d_size), 32'd0);
    chk("rst d_denied", 32'(d_denied), 32'd0);
    chk("rst d_corrupt", 32'(d_corrupt), 32'd0);
    chk("rst d_data", d_data, 32'd0);

    req(3'd0, 3'd2, BASE + 28'd4, 4'hF, 32'hDEADBEEF, 5'd3, r, lat);
    chk("putfull op", 32'(r.op), 32'd0);
    chk("putfull den", 32'(r.den), 32'd0);
    chk("putfull src", 32'(r.src), 32'd3);
    chk("putfull lat", 32'(lat), 32'd1);
    req(3'd4, 3'd2, BASE + 28'd4, 4'hF, 32'd0, 5'd7, r, lat);
    chk("get op", 32'(r.op), 32'd1);
    chk("get data", r.data, 32'hDEADBEEF);
    chk("get src", 32'(r.src), 32'd7);
    chk("get cor", 32'(r.cor), 32'd0);
    chk("get lat", 32'(lat), 32'd1);
    req(3'd1, 3'd2, BASE + 28'd4, 4'b0010, 32'h0000AB00, 5'd1, r, lat);
    chk("partial den", 32'(r.den), 32'd0);
    req(3'd4, 3'd2, BASE + 28'd4, 4'hF, 32'd0, 5'd2, r, lat);
    chk("partial readback", r.data, 32'hDEADABEF);
    req(3'd4, 3'd2, BASE + 28'(4 * NR), 4'hF, 32'd0, 5'd4, r, lat);
    chk("oor den", 32'(r.den), 32'd1);
    chk("oor cor", 32'(r.cor), 32'd1);
    chk("oor data", r.data, 32'd0);
    req(3'd4, 3'd3, BASE, 4'hF, 32'd0, 5'd5, r, lat);
    chk("size3 den", 32'(r.den), 32'd1);
    chk("size3 cor", 32'(r.cor), 32'd1);
    chk("size3 data", r.data, 32'd0);
    req(3'd1, 3'd1, BASE + 28'd5, 4'b0110, 32'hFFFFFFFF, 5'd6, r, lat);
    chk("misalign op", 32'(r.op), 32'd0);
    chk("misalign den", 32'(r.den), 32'd1);
    chk("misalign cor", 32'(r.cor), 32'd0);
    req(3'd4, 3'd2, BASE + 28'd4, 4'hF, 32'd0, 5'd8, r, lat);
    chk("misalign unchanged", r.data, 32'hDEADABEF);
    req(3'd3, 3'd2, BASE, 4'hF, 32'd0, 5'd9, r, lat);
    chk("badop op", 32'(r.op), 32'd1);
    chk("badop den", 32'(r.den), 32'd1);
    chk("badop cor", 32'(r.cor), 32'd1);

    @(posedge clock); #1;
    d_ready = 0; a_valid = 1; a_opcode = 3'd4; a_size = 3'd2; a_address = BASE + 28'd4;
    a_mask = 4'hF; a_source = 5'd10;
    @(negedge clock);
    chk("bp accept", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    a_opcode = 3'd0; a_data = 32'd0;
    repeat (5) begin
      @(negedge clock);
      chk("bp d_valid", 32'(d_valid), 32'd1);
      chk("bp d_data", d_data, 32'hDEADABEF);
      chk("bp a_ready", 32'(a_ready), 32'd0);
    end
    @(posedge clock); #1;
    a_valid = 0; d_ready = 1;

    foreach (vals[i]) vals[i] = $urandom;
    for (int i = 0; i < 4; i++) req(3'd0, 3'd2, BASE + 28'(4 * i), 4'hF, vals[i], 5'(i), r, lat);
    for (int i = 0; i <= 4; i++) begin
      @(posedge clock); #1;
      if (i < 4) begin
        a_valid = 1; a_opcode = 3'd4; a_size = 3'd2; a_address = BASE + 28'(4 * i);
        a_mask = 4'hF; a_source = 5'(i);
      end else a_valid = 0;
      @(negedge clock);
      if (i < 4) chk("b2b a_ready", 32'(a_ready), 32'd1);
      if (i > 0) begin
        chk("b2b d_valid", 32'(d_valid), 32'd1);
        chk("b2b d_data", d_data, vals[i-1]);
      end
    end

    @(posedge clock); #1;
    d_ready = 0; a_valid = 1; a_opcode = 3'd4; a_size = 3'd2; a_address = BASE + 28'd4; a_mask = 4'hF;
    @(negedge clock);
    @(posedge clock); #1;
    a_valid = 0;
    @(negedge clock);
    chk("pre-rst d_valid", 32'(d_valid), 32'd1);
    @(posedge clock); #3;
    reset_n = 0;
    #1 chk("rst async d_valid", 32'(d_valid), 32'd0);
    @(posedge clock); #2;
    reset_n = 1; d_ready = 1;
    req(3'd4, 3'd2, BASE + 28'd4, 4'hF, 32'd0, 5'd11, r, lat);
    chk("post-rst data", r.data, 32'd0);
    chk("post-rst den", 32'(r.den), 32'd0);

    repeat (400) begin
      int pick;
      @(posedge clock); #1;
      a_valid   = $urandom_range(0, 9) < 7;
      pick      = $urandom_range(0, 4);
      a_opcode  = pick == 0 ? 3'd0 : pick == 1 ? 3'd1 : pick == 4 ? 3'($urandom) : 3'd4;
      a_size    = $urandom_range(0, 7) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
      a_address = BASE - 28'd4 + 28'($urandom_range(0, NR * 4 + 8));
      pick      = $urandom_range(0, 3);
      a_mask    = pick == 0 ? 4'($urandom) : pick == 1 ? 4'hF :
                  pick == 2 ? 4'b0001 << a_address[1:0] : 4'b0011 << {a_address[1], 1'b0};
      a_data    = $urandom;
      a_source  = 5'($urandom);
      a_param   = 3'($urandom);
      d_ready   = $urandom_range(0, 3) != 0;
    end
    @(posedge clock); #1;
    a_valid = 0; d_ready = 1;
    repeat (3) @(posedge clock);

    for (int t = 0; t < 2; t++) begin
      @(posedge clock); #1;
      a_valid3 = 1; a_opcode3 = t == 0 ? 3'd0 : 3'd4; a_size3 = 3'd2; a_address3 = BASE3 + 28'd8;
      a_mask3 = 4'hF; a_data3 = 32'h12345678; a_source3 = 5'(9 + t);
      @(negedge clock);
      chk("w3 a_ready idle", 32'(a_ready3), 32'd1);
      @(posedge clock); #1;
      a_valid3 = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clock);
        chk("w3 d_valid", 32'(d_valid3), 32'(k == 4));
        chk("w3 a_ready busy", 32'(a_ready3), 32'd0);
      end
      chk("w3 d_opcode", 32'(d_opcode3), 32'(t));
      chk("w3 d_source", 32'(d_source3), 32'(9 + t));
      chk("w3 d_denied", 32'(d_denied3), 32'd0);
      if (t == 1) chk("w3 d_data", d_data3, 32'h12345678);
    end
    @(posedge clock); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
